// File: rtl/ram_dp_fifo_ctrl.sv
// Streaming FIFO controller around a dual-port synchronous RAM: port 0 writes, port 1 reads,
// and a two-entry output buffer hides the RAM's registered read latency.
module ram_dp_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] ram_address_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic                  ram_cs_0,
  output logic                  ram_we_0,
  output logic                  ram_oe_0,
  output logic [ADDR_WIDTH-1:0] ram_address_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1,
  output logic                  ram_cs_1,
  output logic                  ram_we_1,
  output logic                  ram_oe_1
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  ram_en_q, ram_en_d;

  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] buf_occ;

  assign wr_ready = (ram_cnt_q < CW'(DEPTH));
  assign push     = rst_n && wr_valid && wr_ready;
  assign rd_valid = (out_cnt_q != 2'd0);
  assign pop      = rd_valid && rd_ready;

  // Buffer slots that will still be claimed after this edge; a new read may only be
  // issued if its data is guaranteed a free slot when it returns.
  assign buf_occ = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = (ram_cnt_q != '0) && (buf_occ < 3'd2);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(issue);
    inflight_d = issue;
    ram_en_d   = 1'b1;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
  end

  // Output buffer: returning read data lands in the head if it is free or leaving,
  // otherwise in the skid slot; a pop promotes the skid entry.
  always_comb begin
    head_d    = head_q;
    skid_d    = skid_q;
    out_cnt_d = out_cnt_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (out_cnt_q == 2'd0) begin
          head_d    = ram_data_1;
          out_cnt_d = 2'd1;
        end else begin
          skid_d    = ram_data_1;
          out_cnt_d = 2'd2;
        end
      end
      2'b11: begin
        if (out_cnt_q == 2'd2) begin
          head_d = skid_q;
          skid_d = ram_data_1;
        end else begin
          head_d = ram_data_1;
        end
      end
      2'b01: begin
        if (out_cnt_q == 2'd2) begin
          head_d = skid_q;
        end
        out_cnt_d = out_cnt_q - 2'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      out_cnt_q  <= 2'd0;
      head_q     <= '0;
      ram_en_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      out_cnt_q  <= out_cnt_d;
      head_q     <= head_d;
      ram_en_q   <= ram_en_d;
    end
  end

  // The skid entry is only meaningful while out_cnt_q == 2, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign rd_data = head_q;
  assign count   = ram_cnt_q + CW'(inflight_q) + CW'(out_cnt_q);
  assign empty   = (count == '0);
  assign full    = !wr_ready;

  assign ram_address_0 = push ? wr_ptr_q : '0;
  assign ram_data_0    = push ? wr_data : '0;
  assign ram_cs_0      = push;
  assign ram_we_0      = push;
  assign ram_oe_0      = 1'b0;

  assign ram_address_1 = rd_ptr_q;
  assign ram_cs_1      = ram_en_q;
  assign ram_oe_1      = ram_en_q;
  assign ram_we_1      = 1'b0;

endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// Bench for ram_dp_fifo_ctrl: a behavioural RAM, a directed vector table, hand-written
// corner sequences and randomized traffic scored against a queue-based FIFO model.
module tb_ram_dp_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ready = 1'b0;
  logic          wr_ready, rd_valid, empty, full;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic [AW-1:0] ram_address_0, ram_address_1;
  logic [DW-1:0] ram_data_0;
  logic [DW-1:0] ram_data_1 = '0;
  logic          ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_we_1, ram_oe_1;

  always #5 clk = ~clk;

  ram_dp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .empty(empty), .full(full),
    .ram_address_0(ram_address_0), .ram_data_0(ram_data_0),
    .ram_cs_0(ram_cs_0), .ram_we_0(ram_we_0), .ram_oe_0(ram_oe_0),
    .ram_address_1(ram_address_1), .ram_data_1(ram_data_1),
    .ram_cs_1(ram_cs_1), .ram_we_1(ram_we_1), .ram_oe_1(ram_oe_1)
  );

  // Dual-port RAM with registered read on port 1; a read sees the pre-edge contents.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_cs_0 && ram_we_0) mem[ram_address_0] <= ram_data_0;
    if (ram_cs_1 && ram_oe_1 && !ram_we_1) ram_data_1 <= mem[ram_address_1];
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // FIFO model: contents, push cycle of each word, and total pushes since reset.
  logic [DW-1:0] mq[$];
  int            tq[$];
  int            wr_idx = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            pops_total, first_pop, last_pop, max_count, stalls;
  logic [DW-1:0] first_pop_data;

  task automatic clear_stats();
    pops_total = 0; first_pop = -1; last_pop = -1; max_count = 0; stalls = 0;
    first_pop_data = '0;
  endtask

  task automatic step(input logic r, input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic acc_w, acc_r;
    @(negedge clk);
    rst_n = r; wr_valid = wv; wr_data = wd; rd_ready = rr;
    #1;
    acc_w = r && wv && wr_ready;
    acc_r = r && rd_valid && rr;
    if (r) begin
      check("ram_cs_0", int'(ram_cs_0), int'(acc_w));
      check("ram_we_0", int'(ram_we_0), int'(acc_w));
      check("ram_oe_0", int'(ram_oe_0), 0);
      check("ram_we_1", int'(ram_we_1), 0);
      if (acc_w) begin
        check("ram_address_0", int'(ram_address_0), wr_idx % DEPTH);
        check("ram_data_0", int'(ram_data_0), int'(wd));
      end
      if (mq.size() < DEPTH) check("wr_ready_below_depth", int'(wr_ready), 1);
      if (mq.size() == DEPTH + 2) check("wr_ready_at_max", int'(wr_ready), 0);
      check("full_vs_ready", int'(full), int'(!wr_ready));
      if (prev_hold) begin
        check("hold_valid", int'(rd_valid), 1);
        check("hold_data", int'(rd_data), int'(prev_data));
      end
      if (acc_r) begin
        check("pop_nonempty", int'(mq.size() > 0), 1);
        if (mq.size() > 0) begin
          check("pop_data", int'(rd_data), int'(mq[0]));
          check("pop_latency_ge3", int'((cyc - tq[0]) >= 3), 1);
          void'(mq.pop_front());
          void'(tq.pop_front());
        end
        if (first_pop < 0) begin
          first_pop = cyc;
          first_pop_data = rd_data;
        end
        last_pop = cyc;
        pops_total++;
      end
      if (acc_w) begin
        mq.push_back(wd);
        tq.push_back(cyc);
        wr_idx++;
      end
      if (wv && !wr_ready) stalls++;
      prev_hold = rd_valid && !rr;
      prev_data = rd_data;
    end else begin
      mq.delete();
      tq.delete();
      wr_idx = 0;
      prev_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("count", int'(count), mq.size());
    check("empty", int'(empty), int'(mq.size() == 0));
    if (!r) begin
      check("rst_rd_valid", int'(rd_valid), 0);
      check("rst_rd_data", int'(rd_data), 0);
      check("rst_wr_ready", int'(wr_ready), 1);
      check("rst_ram_cs_1", int'(ram_cs_1), 0);
      check("rst_ram_cs_0", int'(ram_cs_0), 0);
    end else begin
      check("ram_cs_1", int'(ram_cs_1), 1);
      check("ram_oe_1", int'(ram_oe_1), 1);
    end
    if (int'(count) > max_count) max_count = int'(count);
  endtask

  typedef struct {
    logic          r;
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    int            e_cnt;
    logic          e_empty;
    logic          e_wrr;
    logic          e_cs1;
    logic          chk_rd;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, g;
    // r  wv  wd     rr | rv  rd     cnt empty wrr  cs1  chk_rd
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 2, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 2, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst_n = tbl[i].r; wr_valid = tbl[i].wv; wr_data = tbl[i].wd; rd_ready = tbl[i].rr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_rd_valid", i), int'(rd_valid), int'(tbl[i].e_rv));
      check($sformatf("vec%0d_count", i), int'(count), tbl[i].e_cnt);
      check($sformatf("vec%0d_empty", i), int'(empty), int'(tbl[i].e_empty));
      check($sformatf("vec%0d_wr_ready", i), int'(wr_ready), int'(tbl[i].e_wrr));
      check($sformatf("vec%0d_ram_cs_1", i), int'(ram_cs_1), int'(tbl[i].e_cs1));
      check($sformatf("vec%0d_ram_cs_0", i), int'(ram_cs_0), int'(tbl[i].r && tbl[i].wv && tbl[i].e_wrr));
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rd_data", i), int'(rd_data), int'(tbl[i].e_rd));
      if (!tbl[i].r) begin
        check($sformatf("vec%0d_ram_address_0", i), int'(ram_address_0), 0);
        check($sformatf("vec%0d_ram_address_1", i), int'(ram_address_1), 0);
        check($sformatf("vec%0d_ram_data_0", i), int'(ram_data_0), 0);
        check($sformatf("vec%0d_full", i), int'(full), 0);
      end
    end

    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Back-to-back stream with the consumer always ready.
    clear_stats();
    t0 = cyc;
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
    check("stream_pops", pops_total, 256);
    check("stream_first_latency", first_pop - t0, 3);
    check("stream_gapless", last_pop - first_pop + 1, 256);
    check("stream_max_count_le3", int'(max_count <= 3), 1);
    check("stream_no_stall", stalls, 0);

    // Consumer stalls in a 1,0,0,1 pattern while the producer streams.
    clear_stats();
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 8'(8'h40 + i), ((i % 4) == 0) || ((i % 4) == 3));
    g = 0;
    while (mq.size() > 0 && g < 60) begin
      step(1'b1, 1'b0, 8'h00, 1'b1);
      g++;
    end
    check("stall_drained", mq.size(), 0);
    check("stall_pops", pops_total, 64);

    // Fill to the limit with the consumer blocked, then drain.
    clear_stats();
    g = 0;
    while (mq.size() < DEPTH + 2 && g < 400) begin
      step(1'b1, 1'b1, 8'(mq.size()), 1'b0);
      g++;
    end
    check("fill_accepted", mq.size(), DEPTH + 2);
    check("fill_no_early_stall", stalls, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hEE, 1'b0);
    check("fill_count", int'(count), DEPTH + 2);
    check("fill_full", int'(full), 1);
    check("fill_rejected", stalls, 3);
    g = 0;
    while (mq.size() > 0 && g < 300) begin
      step(1'b1, 1'b0, 8'h00, 1'b1);
      g++;
    end
    check("fill_drain_pops", pops_total, DEPTH + 2);
    check("fill_drain_empty", int'(empty), 1);

    // Reset with five words held and a read in flight.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h51 + i), 1'b0);
    step(1'b1, 1'b1, 8'h56, 1'b1);
    check("mid_count5", int'(count), 5);
    step(1'b0, 1'b1, 8'h77, 1'b0);
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_rd_valid", int'(rd_valid), 0);
    clear_stats();
    t0 = cyc;
    step(1'b1, 1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
    check("mid_first_latency", first_pop - t0, 3);
    check("mid_first_word", int'(first_pop_data), 8'h3C);
    check("mid_pops", pops_total, 1);

    // Randomized traffic alternating drain-heavy and fill-heavy phases.
    clear_stats();
    for (int i = 0; i < 3000; i++) begin
      logic wv_r, rr_r;
      if (((i / 500) % 2) == 1) begin
        wv_r = ($urandom_range(0, 99) < 90);
        rr_r = ($urandom_range(0, 99) < 20);
      end else begin
        wv_r = ($urandom_range(0, 99) < 60);
        rr_r = ($urandom_range(0, 99) < 80);
      end
      step(1'b1, wv_r, 8'($urandom), rr_r);
    end
    g = 0;
    while (mq.size() > 0 && g < 400) begin
      step(1'b1, 1'b0, 8'h00, 1'b1);
      g++;
    end
    check("rand_drained", mq.size(), 0);
    check("rand_empty", int'(empty), 1);
    check("rand_reached_full", int'(max_count >= DEPTH), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
